dram_responder: RTL and testbench

Behavioural-synthesizable data-memory responder that serves the DLX core's read/write data-memory handshake from the memory side. It accepts one request at a time (ADDRESS, ENABLE, READNOTWRITE, INOUT_DATA), waits a programmable latency, then completes it with a one-cycle DATA_READY pulse, driving read data onto the shared bidirectional bus. It sits behind the rw memory interface in the UVM testbench and in FPGA bring-up builds, replacing the ideal memory model.

---
 rtl/dram_resp_pkg.sv | 9 +
 rtl/dram_responder_if.sv | 13 +
 rtl/dram_resp_array.sv | 20 ++
 rtl/dram_responder.sv | 80 ++++++++
 tb/tb_dram_responder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dram_resp_pkg.sv
// dram_resp_pkg: FSM states, default geometry and counter width shared by dram_responder
package dram_resp_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int DEPTH_DEF = 64;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;
endpackage

// File: rtl/dram_responder_if.sv
// dram_responder_if: request/completion handshake between the DLX data port and dram_responder
interface dram_responder_if import dram_resp_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] ADDRESS;
    logic ENABLE;
    logic READNOTWRITE;
    logic DATA_READY;
    logic busy;
    logic err;
    modport master (output ADDRESS, ENABLE, READNOTWRITE, input DATA_READY, busy, err);
    modport slave (input ADDRESS, ENABLE, READNOTWRITE, output DATA_READY, busy, err);
endinterface

// File: rtl/dram_resp_array.sv
// dram_resp_array: DEPTH x DATA_W storage with one synchronous write and one synchronous read port
module dram_resp_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/dram_responder.sv
// dram_responder: latency-programmable data-memory responder on a shared tri-state bus
// address/range error reporting is built only with DRAM_RESP_ERR_CHECK_EN defined
module dram_responder import dram_resp_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input logic                clk,
    input logic                rst,
    dram_responder_if.slave    mem_if,
    inout wire  [DATA_W-1:0]   INOUT_DATA
);
    localparam int IDX_W = $clog2(DEPTH);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, cur_idx;
    logic [DATA_W-1:0] wdata, cur_wdata, rdata;
    logic rnw, bad, addr_bad, in_bad, acc, cur_rnw, cur_bad, enter_ready;
    assign addr_bad = |mem_if.ADDRESS[1:0] || (mem_if.ADDRESS >> (IDX_W + 2)) != '0;
`ifdef DRAM_RESP_ERR_CHECK_EN
    assign in_bad = addr_bad;
`else
    logic unused_addr;
    assign in_bad = 1'b0;
    assign unused_addr = addr_bad;
`endif
    assign acc = state == IDLE && mem_if.ENABLE;
    // a zero-latency request hits the array on its capture edge, so bypass the request registers
    assign cur_idx = acc ? mem_if.ADDRESS[IDX_W+1:2] : idx;
    assign cur_rnw = acc ? mem_if.READNOTWRITE : rnw;
    assign cur_bad = acc ? in_bad : bad;
    assign cur_wdata = acc ? INOUT_DATA : wdata;
    assign enter_ready = rst && state_n == READY;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (mem_if.ENABLE) begin
                state_n = LATENCY == 0 ? READY : BUSY;
                cnt_n = CNT_W'(LATENCY == 0 ? 0 : LATENCY - 1);
            end
            BUSY: begin
                state_n = cnt == '0 ? READY : BUSY;
                cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    always_ff @(posedge clk) begin
        if (acc) begin
            idx <= mem_if.ADDRESS[IDX_W+1:2];
            rnw <= mem_if.READNOTWRITE;
            bad <= in_bad;
            wdata <= INOUT_DATA;
        end
    end
    dram_resp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk,
        .we(enter_ready && !cur_rnw && !cur_bad),
        .waddr(cur_idx),
        .wdata(cur_wdata),
        .re(enter_ready && cur_rnw),
        .raddr(cur_idx),
        .rdata
    );
    assign mem_if.DATA_READY = state == READY;
    assign mem_if.busy = state != IDLE;
    assign mem_if.err = state == READY && bad;
    assign INOUT_DATA = (state == READY && rnw) ? (bad ? '0 : rdata) : 'z;
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed + random requests at LATENCY 2 and 0 against an edge-numbered reference
module tb_dram_responder;
    import dram_resp_pkg::*;
    localparam int DEPTH = 64;
    localparam int NLAT = 2;
    localparam int D = DEPTH;
`ifdef DRAM_RESP_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif
    typedef struct {
        logic [31:0] a;
        bit          rnw;
        logic [31:0] d;
        int          gap;
        bit          rs;
    } op_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    bit done [NLAT];
    function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction
    function automatic bit is_bad(logic [31:0] a);
        return ERR_ON && (a[1:0] != 2'b00 || (a >> 2) >= DEPTH);
    endfunction
    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction
    function automatic op_t mk(logic [31:0] a, bit rnw, logic [31:0] d, int gap, bit rs);
        op_t o;
        o.a = a; o.rnw = rnw; o.d = d; o.gap = gap; o.rs = rs;
        return o;
    endfunction
    for (genvar g = 0; g < NLAT; g++) begin : inst
        localparam int LAT = g == 0 ? 2 : 0;
        localparam int DLY = g == 0 ? 3 : 1;
        localparam int SPACE = g == 0 ? 4 : 2;
        localparam logic [31:0] EXP8 = g == 0 ? 32'h11111111 : 32'hAAAA5555;
        localparam bit DR5 = g != 0;
        logic rst = 1'b0;
        logic rel = 1'b0;
        logic [31:0] drv = '0;
        wire [31:0] data;
        assign data = rel ? 'z : drv;
        dram_responder_if ifc ();
        dram_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
            .clk, .rst, .mem_if(ifc), .INOUT_DATA(data)
        );
        // reference: requests numbered by acceptance, outcomes tied to edge numbers
        int n = 0, rdy_e = 0, cur = 0, nacc = 0;
        bit live = 0, pend = 0, rr = 0, exp_known = 0, rnow;
        logic [31:0] ra, rd, exp_data;
        logic [31:0] mem [DEPTH];
        bit known [DEPTH];
        int acc_at [int];
        int dr_at [int];
        logic [31:0] got [int];
        bit got_err [int];
        always @(posedge clk) begin
            n++;
            if (!rst) begin
                pend = 0;
                live = 1;
            end else if (pend && n == rdy_e + 1) pend = 0;
            else if (!pend && ifc.ENABLE) begin
                pend = 1; rdy_e = n + LAT; cur = nacc; nacc++; acc_at[cur] = n;
                ra = ifc.ADDRESS; rr = ifc.READNOTWRITE; rd = drv;
            end
            if (rst && pend && n == rdy_e) begin
                if (rr) begin
                    exp_known = is_bad(ra) || known[widx(ra)];
                    exp_data = is_bad(ra) ? 32'h0 : mem[widx(ra)];
                end else if (!is_bad(ra)) begin
                    mem[widx(ra)] = rd;
                    known[widx(ra)] = 1;
                end
            end
        end
        always @(negedge clk) if (live) begin
            rnow = pend && n == rdy_e;
            chk(ifc.DATA_READY === rnow, $sformatf("L%0d_dready@%0d", LAT, n), 32'(ifc.DATA_READY), 32'(rnow));
            chk(ifc.busy === pend, $sformatf("L%0d_busy@%0d", LAT, n), 32'(ifc.busy), 32'(pend));
            chk(ifc.err === (rnow && is_bad(ra)), $sformatf("L%0d_err@%0d", LAT, n), 32'(ifc.err), 32'(rnow && is_bad(ra)));
            if (rnow && rr) begin
                if (exp_known) chk(data === exp_data, $sformatf("L%0d_rdata@%0d", LAT, n), data, exp_data);
                got[cur] = data;
            end else chk(data === drv, $sformatf("L%0d_bus_released@%0d", LAT, n), data, drv);
            if (rnow) begin
                dr_at[cur] = n;
                got_err[cur] = ifc.err;
            end
        end
        task automatic step();
            @(posedge clk);
            #1;
            rel = pend && n == rdy_e && rr;
            if (!rel) drv = $urandom;
        endtask
        initial begin
            op_t ops[$];
            int t;
            ifc.ENABLE = 0; ifc.ADDRESS = '0; ifc.READNOTWRITE = 0;
            for (int i = 0; i < DEPTH; i++) ops.push_back(mk(32'(i) << 2, 0, $urandom, 0, 0));
            ops.push_back(mk(32'h10, 0, 32'hDEADBEEF, 0, 0));
            ops.push_back(mk(32'h10, 1, 0, 0, 0));
            ops.push_back(mk(32'h04, 0, 32'h12345678, 3, 0));
            ops.push_back(mk(32'h04, 1, 0, 1, 0));
            ops.push_back(mk(32'h08, 0, 32'h11111111, 1, 0));
            ops.push_back(mk(32'h08, 0, 32'hAAAA5555, 1, 1));
            ops.push_back(mk(32'h08, 1, 0, 0, 0));
            ops.push_back(mk(32'h10, 1, 0, 0, 0));
            ops.push_back(mk(32'h04, 1, 0, 0, 0));
            ops.push_back(mk(32'h100, 0, 32'hCAFEF00D, 0, 0));
            ops.push_back(mk(32'h000, 1, 0, 0, 0));
            ops.push_back(mk(32'h102, 1, 0, 2, 0));
            repeat (200) ops.push_back(mk($urandom_range(0, 7) == 0 ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, DEPTH - 1)) << 2,
                1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0, $urandom_range(0, 19) == 0));
            repeat (2) step();
            rst = 1;
            foreach (ops[i]) begin
                ifc.ENABLE = 1; ifc.ADDRESS = ops[i].a; ifc.READNOTWRITE = ops[i].rnw;
                t = 0;
                do begin
                    if (!ops[i].rnw && !rel) drv = ops[i].d;
                    step();
                    t++;
                end while (!acc_at.exists(i) && t < 100);
                if (!acc_at.exists(i)) chk(0, $sformatf("L%0d_accept_timeout_op%0d", LAT, i), 32'(t), 32'd100);
                if (ops[i].rs && LAT > 0) begin
                    ifc.ENABLE = 0;
                    rst = 0;
                    step();
                    rst = 1;
                end
                if (ops[i].gap > 0) ifc.ENABLE = 0;
                repeat (ops[i].gap) step();
            end
            ifc.ENABLE = 0;
            for (int k = 0; k < 100 && pend; k++) step();
            chk(got[D + 1] === 32'hDEADBEEF, $sformatf("L%0d_read_deadbeef", LAT), got[D + 1], 32'hDEADBEEF);
            chk(dr_at[D] - acc_at[D] + 1 == DLY, $sformatf("L%0d_write_delay", LAT), 32'(dr_at[D] - acc_at[D] + 1), 32'(DLY));
            chk(dr_at[D + 1] - acc_at[D + 1] + 1 == DLY, $sformatf("L%0d_read_delay", LAT), 32'(dr_at[D + 1] - acc_at[D + 1] + 1), 32'(DLY));
            chk(got[D + 3] === 32'h12345678, $sformatf("L%0d_enable_drop_read", LAT), got[D + 3], 32'h12345678);
            chk(dr_at.exists(D + 5) == DR5, $sformatf("L%0d_reset_pulse", LAT), 32'(dr_at.exists(D + 5)), 32'(DR5));
            chk(got[D + 6] === EXP8, $sformatf("L%0d_reset_readback", LAT), got[D + 6], EXP8);
            chk(acc_at[D + 8] - acc_at[D + 7] == SPACE, $sformatf("L%0d_accept_spacing", LAT), 32'(acc_at[D + 8] - acc_at[D + 7]), 32'(SPACE));
`ifdef DRAM_RESP_ERR_CHECK_EN
            chk(got_err[D + 9] === 1'b1, $sformatf("L%0d_err_write_range", LAT), 32'(got_err[D + 9]), 32'd1);
            chk(got_err[D + 11] === 1'b1, $sformatf("L%0d_err_read_misalign", LAT), 32'(got_err[D + 11]), 32'd1);
            chk(got[D + 11] === 32'h0, $sformatf("L%0d_err_read_zero", LAT), got[D + 11], 32'h0);
`else
            chk(got[D + 10] === 32'hCAFEF00D, $sformatf("L%0d_wrap_read", LAT), got[D + 10], 32'hCAFEF00D);
            chk(got[D + 11] === 32'hCAFEF00D, $sformatf("L%0d_wrap_lsb_ignored", LAT), got[D + 11], 32'hCAFEF00D);
            chk(got_err[D + 9] === 1'b0, $sformatf("L%0d_err_tied", LAT), 32'(got_err[D + 9]), 32'd0);
`endif
            done[g] = 1;
        end
    end
    initial begin
        for (int c = 0; c < 20000 && !(done[0] && done[1]); c++) @(posedge clk);
        if (!(done[0] && done[1])) chk(0, "run_timeout", 32'(done[0]), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
